bnn_neuron_array: RTL

Parametrised binary-neuron layer engine: N_NEURONS XNOR-popcount neurons share one input-vector stream and evaluate it in parallel against locally stored weights and thresholds. Weights and thresholds load over a single serial config stream. Input words arrive over a valid/ready stream, one PW-bit word per beat. Each completed vector produces one N_NEURONS-bit activation word on an output valid/ready stream. It replaces the single-neuron wrapper as the building block of a fully-connected BNN layer.

---
 rtl/bnn_pkg.sv | 28 ++
 rtl/bnn_xnor_popcount.sv | 25 ++
 rtl/bnn_neuron_array.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary-neuron layer engine.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_CFG  = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam int MIN_PW        = 1;
    localparam int MIN_IN_WORDS  = 1;
    localparam int MIN_N_NEURONS = 1;

    // Bits needed to hold a popcount of a pw-bit word (0..pw inclusive).
    function automatic int popcnt_w(input int pw);
        return $clog2(pw + 1);
    endfunction

    // THRESH_W must fit in a config word and hold the full-vector popcount.
    function automatic bit params_legal(input int pw, input int thresh_w,
                                        input int in_words, input int n_neurons);
        return (pw >= MIN_PW) && (in_words >= MIN_IN_WORDS) &&
               (n_neurons >= MIN_N_NEURONS) && (thresh_w <= pw) &&
               (thresh_w >= $clog2(in_words * pw + 1));
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// One combinational XNOR-popcount lane: counts bit positions where x and w agree.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic [PW-1:0]            x_i,
    input  logic [PW-1:0]            w_i,
    output logic [$clog2(PW+1)-1:0]  pc_o
);

    localparam int PCW = popcnt_w(PW);

    logic [PW-1:0] match;

    assign match = ~(x_i ^ w_i);

    always_comb begin
        pc_o = '0;
        for (int i = 0; i < PW; i++) begin
            pc_o = pc_o + PCW'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_neuron_array.sv
// N_NEURONS parallel XNOR-popcount neurons sharing one input-vector stream.
// Optional macro POPCOUNT_OUT_EN exposes the registered per-neuron popcounts.
module bnn_neuron_array
    import bnn_pkg::*;
#(
    parameter int PW        = 16,
    parameter int THRESH_W  = 16,
    parameter int N_NEURONS = 8,
    parameter int IN_WORDS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [PW-1:0]                 cfg_data,
    output logic                          cfg_done,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [PW-1:0]                 x_data,
    input  logic                          x_last,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [N_NEURONS-1:0]          y_data,
`ifdef POPCOUNT_OUT_EN
    output logic [N_NEURONS*THRESH_W-1:0] popcount_out,
`endif
    output logic                          len_err
);

    localparam int PCW = popcnt_w(PW);
    localparam int KW  = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int CKW = $clog2(IN_WORDS + 1);
    localparam int NW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    localparam logic [KW-1:0]  K_LAST = KW'(IN_WORDS - 1);
    localparam logic [CKW-1:0] CK_THR = CKW'(IN_WORDS);
    localparam logic [NW-1:0]  N_LAST = NW'(N_NEURONS - 1);

    if (!params_legal(PW, THRESH_W, IN_WORDS, N_NEURONS)) begin : g_bad_params
        $error("bnn_neuron_array: illegal PW/THRESH_W/IN_WORDS/N_NEURONS combination");
    end

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [THRESH_W-1:0]    acc_q [N_NEURONS];
    logic [THRESH_W-1:0]    acc_d [N_NEURONS];
    logic [N_NEURONS-1:0]   y_q, y_d;
    logic                   len_err_q, len_err_d;
    logic                   cfg_done_q, cfg_done_d;
    logic [NW-1:0]          cfg_n_q, cfg_n_d;
    logic [CKW-1:0]         cfg_k_q, cfg_k_d;
`ifdef POPCOUNT_OUT_EN
    logic [N_NEURONS*THRESH_W-1:0] pc_q, pc_d;
`endif

    logic [PW-1:0]          w_q      [N_NEURONS][IN_WORDS];
    logic [THRESH_W-1:0]    thresh_q [N_NEURONS];
    logic [PCW-1:0]         lane_pc  [N_NEURONS];
    logic [THRESH_W-1:0]    sum      [N_NEURONS];
    logic                   cfg_beat;

    // cfg_start wins over a coincident config beat, so that beat is dropped.
    assign cfg_beat = cfg_valid && (state_q == ST_CFG) && !cfg_start;

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_lane
        bnn_xnor_popcount #(.PW(PW)) u_lane (
            .x_i  (x_data),
            .w_i  (w_q[n][k_q]),
            .pc_o (lane_pc[n])
        );
        assign sum[n] = acc_q[n] + THRESH_W'(lane_pc[n]);
    end

    always_ff @(posedge clk) begin
        if (cfg_beat) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                for (int k = 0; k < IN_WORDS; k++) begin
                    if (cfg_n_q == NW'(n) && cfg_k_q == CKW'(k)) begin
                        w_q[n][k] <= cfg_data;
                    end
                end
                if (cfg_n_q == NW'(n) && cfg_k_q == CK_THR) begin
                    thresh_q[n] <= cfg_data[THRESH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        y_d        = y_q;
        len_err_d  = len_err_q;
        cfg_done_d = cfg_done_q;
        cfg_n_d    = cfg_n_q;
        cfg_k_d    = cfg_k_q;
        for (int n = 0; n < N_NEURONS; n++) acc_d[n] = acc_q[n];
`ifdef POPCOUNT_OUT_EN
        pc_d       = pc_q;
`endif
        case (state_q)
            ST_CFG: begin
                if (cfg_start) begin
                    cfg_n_d    = '0;
                    cfg_k_d    = '0;
                    cfg_done_d = 1'b0;
                    len_err_d  = 1'b0;
                end else if (cfg_valid) begin
                    if (cfg_k_q == CK_THR) begin
                        cfg_k_d = '0;
                        if (cfg_n_q == N_LAST) begin
                            cfg_n_d    = '0;
                            cfg_done_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            cfg_n_d = cfg_n_q + 1'b1;
                        end
                    end else begin
                        cfg_k_d = cfg_k_q + 1'b1;
                    end
                end
            end
            ST_IDLE, ST_ACC: begin
                if (cfg_start && state_q == ST_IDLE) begin
                    cfg_n_d    = '0;
                    cfg_k_d    = '0;
                    cfg_done_d = 1'b0;
                    len_err_d  = 1'b0;
                    k_d        = '0;
                    for (int n = 0; n < N_NEURONS; n++) acc_d[n] = '0;
                    state_d    = ST_CFG;
                end else if (x_valid) begin
                    if (k_q == K_LAST) begin
                        for (int n = 0; n < N_NEURONS; n++) begin
                            y_d[n]   = (sum[n] >= thresh_q[n]);
                            acc_d[n] = '0;
`ifdef POPCOUNT_OUT_EN
                            pc_d[n*THRESH_W +: THRESH_W] = sum[n];
`endif
                        end
                        k_d     = '0;
                        state_d = ST_OUT;
                        if (!x_last) len_err_d = 1'b1;
                    end else if (x_last) begin
                        // Short vector: drop it without producing an output.
                        for (int n = 0; n < N_NEURONS; n++) acc_d[n] = '0;
                        k_d       = '0;
                        len_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        for (int n = 0; n < N_NEURONS; n++) acc_d[n] = sum[n];
                        k_d     = k_q + 1'b1;
                        state_d = ST_ACC;
                    end
                end
            end
            ST_OUT: begin
                if (y_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_CFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CFG;
            k_q        <= '0;
            y_q        <= '0;
            len_err_q  <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_n_q    <= '0;
            cfg_k_q    <= '0;
            for (int n = 0; n < N_NEURONS; n++) acc_q[n] <= '0;
`ifdef POPCOUNT_OUT_EN
            pc_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            y_q        <= y_d;
            len_err_q  <= len_err_d;
            cfg_done_q <= cfg_done_d;
            cfg_n_q    <= cfg_n_d;
            cfg_k_q    <= cfg_k_d;
            for (int n = 0; n < N_NEURONS; n++) acc_q[n] <= acc_d[n];
`ifdef POPCOUNT_OUT_EN
            pc_q       <= pc_d;
`endif
        end
    end

    // Handshakes are pure decodes of the registered state.
    assign cfg_ready = (state_q == ST_CFG);
    assign x_ready   = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign y_valid   = (state_q == ST_OUT);
    assign y_data    = y_q;
    assign cfg_done  = cfg_done_q;
    assign len_err   = len_err_q;
`ifdef POPCOUNT_OUT_EN
    assign popcount_out = pc_q;
`endif

endmodule
